// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory with a registered fetch path and a valid/ready
// output stage. The program is written in LOAD state. Fetches run in RUN state
// with one cycle of latency. The fetched word is also split into decode fields.
module instr_fetch_mem #(
  parameter int unsigned         INSTR_W = 9,
  parameter int unsigned         DEPTH   = 256,
  parameter int unsigned         PC_W    = 16,
  parameter logic [INSTR_W-1:0]  NOP     = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic [PC_W-1:0]    load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  output logic               running,
  input  logic               req,
  input  logic [PC_W-1:0]    pc_in,
  output logic               req_ready,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               oob_fault,
  output logic               format,
  output logic [3:0]         opcode,
  output logic               sign,
  output logic [2:0]         operand,
  output logic [7:0]         immediate
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so that DEPTH == 2**PC_W is still representable.
  localparam logic [PC_W:0] DEPTH_EXT = (PC_W+1)'(DEPTH);

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t state, state_next;

  logic [INSTR_W-1:0] mem [DEPTH];

  logic load_in_range;
  logic fetch_in_range;
  logic accept;

  // Full-width compare of the address against DEPTH. There is no wrap-around.
  assign load_in_range  = {1'b0, load_addr} < DEPTH_EXT;
  assign fetch_in_range = {1'b0, pc_in}     < DEPTH_EXT;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_next;
  end

  // Next state and the handshake outputs.
  always_comb begin
    state_next = state;
    running    = 1'b0;
    req_ready  = 1'b0;
    accept     = 1'b0;
    unique case (state)
      ST_LOAD: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        running   = 1'b1;
        req_ready = !instr_valid || instr_ready;
        accept    = req && req_ready;
      end
      default: state_next = ST_LOAD;
    endcase
  end

  // Program write port. It is active only in LOAD, and reset does not clear the contents.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && load_en && load_in_range)
      mem[load_addr[AW-1:0]] <= load_data;
  end

  // Registered fetch and output stage. On accept it loads a new word.
  // Otherwise it holds its value, so a stall keeps the outputs bit-stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instr_out   <= NOP;
      pc_out      <= '0;
      oob_fault   <= 1'b0;
    end else if (accept) begin
      instr_valid <= 1'b1;
      pc_out      <= pc_in;
      if (fetch_in_range) begin
        instr_out <= mem[pc_in[AW-1:0]];
        oob_fault <= 1'b0;
      end else begin
        instr_out <= NOP;
        oob_fault <= 1'b1;
      end
    end else if (instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

  // Decode fields, taken directly from the low nine bits of the output word.
  always_comb begin
    format    = instr_out[8];
    opcode    = instr_out[7:4];
    sign      = instr_out[3];
    operand   = instr_out[2:0];
    immediate = instr_out[7:0];
  end

endmodule
